mem_port_arbiter: RTL

Sequencer and arbiter for a single-port, word-addressed unified memory shared between the instruction-fetch path and the load/store path of the MIPS core. Each requester gets a request/valid handshake. The block serialises accesses, drives the memory port for a fixed read latency, and returns read data. Load/store has priority, and a streak limit prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_arb_pick.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// State encoding, requester ids and parameter defaults live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_MAX_STREAK = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port bundle between the core and the arbiter.
// Handshake: a requester holds req and its payload stable until its one-cycle valid pulse.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data, with a saturating data-streak counter
// that hands the port to fetch once data has won MAX_STREAK times in a row.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic arb_i,
    output logic win_o
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0] streak_q, streak_d;

    always_comb begin
        win_o = REQ_FETCH;
        if (d_req_i && !(if_req_i && streak_q == STREAK_MAX)) begin
            win_o = REQ_DATA;
        end
    end

    // Streak only grows while fetch is actually being held off.
    always_comb begin
        streak_d = streak_q;
        if (arb_i) begin
            if (win_o == REQ_DATA && if_req_i) begin
                if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + 4'd1;
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto a single-port memory with a fixed
// read latency: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output state_e             dbg_state_o
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        arb;
    logic        win;
    logic        last_wait;

    assign arb       = (state_q == ST_IDLE) && (bus.if_req || bus.d_req);
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == 4'd1);

    mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
        .clk_i    (clock),
        .rst_i    (reset),
        .if_req_i (bus.if_req),
        .d_req_i  (bus.d_req),
        .arb_i    (arb),
        .win_o    (win)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (arb) state_d = ST_ACCESS;
            ST_ACCESS: begin
                state_d = ST_WAIT;
                cnt_d   = LAT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Winner's request is latched on the grant edge; fetch never writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_q    <= REQ_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (arb) begin
            id_q <= win;
            if (win == REQ_DATA) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (last_wait && !we_q) begin
            if (id_q == REQ_FETCH) if_rdata_q <= bus.mem_rdata;
            else                   d_rdata_q  <= bus.mem_rdata;
        end
    end

    assign bus.mem_en    = (state_q == ST_ACCESS);
    assign bus.mem_we    = we_q && (state_q == ST_ACCESS || state_q == ST_WAIT);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_valid  = (state_q == ST_RESP) && (id_q == REQ_FETCH);
    assign bus.d_valid   = (state_q == ST_RESP) && (id_q == REQ_DATA);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

endmodule
